// File: rtl/interrupt_ack_controller_pkg.sv
// rtl/interrupt_ack_controller_pkg.sv - shared types, constants and bit helpers for the 8259A acknowledge path
package interrupt_ack_controller_pkg;

   localparam int         PIC_NUM_IR       = 8;
   localparam logic [2:0] PIC_SPURIOUS_LVL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK1 = 2'd1,
      ST_ACK2 = 2'd2
   } ack_state_e;

   function automatic logic [2:0] onehot_to_bin(input logic [7:0] oh);
      logic [2:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) b = b | i[2:0];
      end
      return b;
   endfunction

   function automatic logic [7:0] bin_to_onehot(input logic [2:0] b);
      return 8'b1 << b;
   endfunction

   // Rotate right so that bit n lands at position 0.
   function automatic logic [7:0] rot_right8(input logic [7:0] v, input logic [2:0] n);
      return (v >> n) | (v << (4'd8 - {1'b0, n}));
   endfunction

endpackage

// File: rtl/interrupt_ack_controller_isr_priority_encoder.sv
// rtl/interrupt_ack_controller_isr_priority_encoder.sv - rotation-aware highest in-service level finder
module interrupt_ack_controller_isr_priority_encoder
   import interrupt_ack_controller_pkg::*;
(
   input  logic [7:0] isr_i,
   input  logic [2:0] priority_rotate_i,
   output logic [7:0] highest_o,
   output logic [2:0] level_o,
   output logic       valid_o
);

   logic [2:0] start;
   logic [7:0] rotated;
   logic [2:0] offset;

   // Level after priority_rotate is the highest priority, so scan from there upward.
   always_comb begin
      start   = priority_rotate_i + 3'd1;
      rotated = rot_right8(isr_i, start);
      offset  = '0;
      for (int i = 7; i >= 0; i--) begin
         if (rotated[i]) offset = i[2:0];
      end
      valid_o   = |isr_i;
      level_o   = offset + start;
      highest_o = valid_o ? bin_to_onehot(level_o) : '0;
   end

endmodule

// File: rtl/interrupt_ack_controller.sv
// rtl/interrupt_ack_controller.sv - INT/INTA handshake, ISR ownership, EOI and priority rotation
module interrupt_ack_controller
   import interrupt_ack_controller_pkg::*;
#(
   parameter int         NUM_IR       = PIC_NUM_IR,
   parameter logic [2:0] SPURIOUS_LVL = PIC_SPURIOUS_LVL
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_IR-1:0] interrupt,
   input  logic              inta_n,
   input  logic [4:0]        vector_base,
   input  logic              auto_eoi_config,
   input  logic              eoi_strobe,
   input  logic              eoi_specific,
   input  logic [2:0]        eoi_level,
   input  logic              rotate_on_eoi,
   output logic              int_out,
   output logic [NUM_IR-1:0] isr,
   output logic [NUM_IR-1:0] highest_level_in_service,
   output logic [NUM_IR-1:0] clear_irr,
   output logic [2:0]        priority_rotate,
   output logic [7:0]        data_out,
   output logic              data_out_en
);

   ack_state_e  state_q, state_d;
   logic        inta_prev_q;
   logic        int_out_q, int_out_d;
   logic [7:0]  isr_q, isr_d;
   logic [7:0]  clear_irr_q, clear_irr_d;
   logic [2:0]  rotate_q, rotate_d;
   logic [2:0]  level_q, level_d;
   logic        spur_q, spur_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        data_out_en_q, data_out_en_d;

   logic        inta_fall, inta_rise;
   logic [7:0]  set_mask, aeoi_mask, eoi_mask;
   logic [2:0]  eoi_lvl;
   logic [7:0]  hlis_onehot;
   logic [2:0]  hlis_level;
   logic        hlis_valid;

   interrupt_ack_controller_isr_priority_encoder u_hlis (
      .isr_i             (isr_q),
      .priority_rotate_i (rotate_q),
      .highest_o         (hlis_onehot),
      .level_o           (hlis_level),
      .valid_o           (hlis_valid)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         inta_prev_q   <= 1'b1;
         int_out_q     <= 1'b0;
         isr_q         <= '0;
         clear_irr_q   <= '0;
         rotate_q      <= 3'b111;
         level_q       <= '0;
         spur_q        <= 1'b0;
         data_out_q    <= '0;
         data_out_en_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         inta_prev_q   <= inta_n;
         int_out_q     <= int_out_d;
         isr_q         <= isr_d;
         clear_irr_q   <= clear_irr_d;
         rotate_q      <= rotate_d;
         level_q       <= level_d;
         spur_q        <= spur_d;
         data_out_q    <= data_out_d;
         data_out_en_q <= data_out_en_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      int_out_d     = int_out_q;
      clear_irr_d   = '0;
      rotate_d      = rotate_q;
      level_d       = level_q;
      spur_d        = spur_q;
      data_out_d    = data_out_q;
      data_out_en_d = data_out_en_q;
      set_mask      = '0;
      aeoi_mask     = '0;
      eoi_mask      = '0;
      eoi_lvl       = hlis_level;
      inta_fall     = inta_prev_q & ~inta_n;
      inta_rise     = ~inta_prev_q & inta_n;

      case (state_q)
         ST_IDLE: begin
            int_out_d = |interrupt;
            if (inta_fall) begin
               int_out_d = 1'b0;
               state_d   = ST_ACK1;
               if (interrupt == '0) begin
                  level_d = SPURIOUS_LVL;
                  spur_d  = 1'b1;
               end else begin
                  level_d     = onehot_to_bin(interrupt);
                  spur_d      = 1'b0;
                  set_mask    = bin_to_onehot(onehot_to_bin(interrupt));
                  clear_irr_d = set_mask;
               end
            end
         end
         ST_ACK1: begin
            int_out_d = 1'b0;
            if (inta_fall) begin
               state_d       = ST_ACK2;
               data_out_d    = {vector_base, level_q};
               data_out_en_d = 1'b1;
            end
         end
         ST_ACK2: begin
            int_out_d = 1'b0;
            if (inta_rise) begin
               state_d       = ST_IDLE;
               data_out_d    = '0;
               data_out_en_d = 1'b0;
               if (auto_eoi_config && !spur_q) aeoi_mask = bin_to_onehot(level_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (eoi_strobe) begin
         if (eoi_specific) begin
            eoi_lvl = eoi_level;
            if (isr_q[eoi_level]) eoi_mask = bin_to_onehot(eoi_level);
         end else if (hlis_valid) begin
            eoi_mask = hlis_onehot;
         end
      end

      // An AEOI and an EOI landing on the same bit rotate to the same level, so one update suffices.
      if (rotate_on_eoi) begin
         if (aeoi_mask != '0 && isr_q[level_q]) rotate_d = level_q;
         if (eoi_mask != '0) rotate_d = eoi_lvl;
      end

      isr_d = (isr_q & ~(eoi_mask | aeoi_mask)) | set_mask;
   end

   assign int_out                  = int_out_q;
   assign isr                      = isr_q;
   assign highest_level_in_service = hlis_onehot;
   assign clear_irr                = clear_irr_q;
   assign priority_rotate          = rotate_q;
   assign data_out                 = data_out_q;
   assign data_out_en              = data_out_en_q;

endmodule

// File: tb/tb_interrupt_ack_controller.sv
// tb/tb_interrupt_ack_controller.sv - directed self-checking bench for interrupt_ack_controller
module tb_interrupt_ack_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] interrupt;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       auto_eoi_config;
   logic       eoi_strobe;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       rotate_on_eoi;
   logic       int_out;
   logic [7:0] isr;
   logic [7:0] highest_level_in_service;
   logic [7:0] clear_irr;
   logic [2:0] priority_rotate;
   logic [7:0] data_out;
   logic       data_out_en;

   int tests = 0;
   int failures = 0;

   interrupt_ack_controller dut (
      .clock                    (clock),
      .reset                    (reset),
      .interrupt                (interrupt),
      .inta_n                   (inta_n),
      .vector_base              (vector_base),
      .auto_eoi_config          (auto_eoi_config),
      .eoi_strobe               (eoi_strobe),
      .eoi_specific             (eoi_specific),
      .eoi_level                (eoi_level),
      .rotate_on_eoi            (rotate_on_eoi),
      .int_out                  (int_out),
      .isr                      (isr),
      .highest_level_in_service (highest_level_in_service),
      .clear_irr                (clear_irr),
      .priority_rotate          (priority_rotate),
      .data_out                 (data_out),
      .data_out_en              (data_out_en)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic eoi(input logic specific, input logic [2:0] lvl, input logic rot);
      eoi_strobe = 1'b1; eoi_specific = specific; eoi_level = lvl; rotate_on_eoi = rot;
      tick;
      eoi_strobe = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; rotate_on_eoi = 1'b0;
   endtask

   task automatic finish_inta;
      inta_n = 1'b1; interrupt = 8'h00; tick;
      inta_n = 1'b0; tick;
      inta_n = 1'b1; tick;
   endtask

   task automatic do_inta(input logic [7:0] irq);
      interrupt = irq; tick;
      inta_n = 1'b0; tick;
      finish_inta;
   endtask

   task automatic test_reset;
      reset = 1'b1; interrupt = 8'h00; inta_n = 1'b1; vector_base = 5'h10;
      auto_eoi_config = 1'b0; eoi_strobe = 1'b0; eoi_specific = 1'b0;
      eoi_level = 3'd0; rotate_on_eoi = 1'b0;
      tick; tick;
      tests++; if (int_out !== 1'b0) begin failures++; $display("FAIL rst_int_out got %b exp 0", int_out); end
      tests++; if (isr !== 8'h00) begin failures++; $display("FAIL rst_isr got %h exp 00", isr); end
      tests++; if (priority_rotate !== 3'd7) begin failures++; $display("FAIL rst_rotate got %0d exp 7", priority_rotate); end
      tests++; if (data_out_en !== 1'b0 || data_out !== 8'h00) begin failures++; $display("FAIL rst_data got en=%b d=%h exp en=0 d=00", data_out_en, data_out); end
      tests++; if (highest_level_in_service !== 8'h00) begin failures++; $display("FAIL rst_hlis got %h exp 00", highest_level_in_service); end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_basic_inta;
      interrupt = 8'h04; vector_base = 5'h10;
      tick;
      tests++; if (int_out !== 1'b1) begin failures++; $display("FAIL t1_int_raise got %b exp 1", int_out); end
      inta_n = 1'b0; tick;
      tests++; if (int_out !== 1'b0) begin failures++; $display("FAIL t1_int_drop got %b exp 0", int_out); end
      tests++; if (isr !== 8'h04) begin failures++; $display("FAIL t1_isr got %h exp 04", isr); end
      tests++; if (clear_irr !== 8'h04) begin failures++; $display("FAIL t1_clear_irr got %h exp 04", clear_irr); end
      tests++; if (data_out_en !== 1'b0) begin failures++; $display("FAIL t1_no_drive_ack1 got %b exp 0", data_out_en); end
      inta_n = 1'b1; interrupt = 8'h00; tick;
      tests++; if (clear_irr !== 8'h00) begin failures++; $display("FAIL t1_clear_irr_pulse got %h exp 00", clear_irr); end
      inta_n = 1'b0; tick;
      tests++; if (data_out_en !== 1'b1 || data_out !== 8'h82) begin failures++; $display("FAIL t1_vector got en=%b d=%h exp en=1 d=82", data_out_en, data_out); end
      inta_n = 1'b1; tick;
      tests++; if (data_out_en !== 1'b0 || isr !== 8'h04) begin failures++; $display("FAIL t1_end got en=%b isr=%h exp en=0 isr=04", data_out_en, isr); end
   endtask

   task automatic test_eoi;
      eoi(1'b1, 3'd2, 1'b0);
      tests++; if (isr !== 8'h00) begin failures++; $display("FAIL t2_clear_prev got %h exp 00", isr); end
      do_inta(8'h02);
      do_inta(8'h08);
      tests++; if (isr !== 8'h0A) begin failures++; $display("FAIL t2_setup got %h exp 0A", isr); end
      tests++; if (highest_level_in_service !== 8'h02) begin failures++; $display("FAIL t2_hlis got %h exp 02", highest_level_in_service); end
      eoi(1'b0, 3'd0, 1'b0);
      tests++; if (isr !== 8'h08) begin failures++; $display("FAIL t2_nonspec got %h exp 08", isr); end
      eoi(1'b1, 3'd3, 1'b0);
      tests++; if (isr !== 8'h00) begin failures++; $display("FAIL t2_spec got %h exp 00", isr); end
      eoi(1'b0, 3'd0, 1'b1);
      tests++; if (isr !== 8'h00 || priority_rotate !== 3'd7) begin failures++; $display("FAIL t2_empty_eoi got isr=%h rot=%0d exp isr=00 rot=7", isr, priority_rotate); end
   endtask

   task automatic test_aeoi;
      auto_eoi_config = 1'b1; vector_base = 5'h05; interrupt = 8'h80;
      tick;
      inta_n = 1'b0; tick;
      tests++; if (isr !== 8'h80) begin failures++; $display("FAIL t3_isr_set got %h exp 80", isr); end
      inta_n = 1'b1; interrupt = 8'h00; tick;
      inta_n = 1'b0; tick;
      tests++; if (data_out !== 8'h2F || isr !== 8'h80) begin failures++; $display("FAIL t3_vector got d=%h isr=%h exp d=2F isr=80", data_out, isr); end
      inta_n = 1'b1; tick;
      tests++; if (isr !== 8'h00 || priority_rotate !== 3'd7) begin failures++; $display("FAIL t3_aeoi got isr=%h rot=%0d exp isr=00 rot=7", isr, priority_rotate); end
      auto_eoi_config = 1'b0;
   endtask

   task automatic test_rotate;
      do_inta(8'h20);
      eoi(1'b0, 3'd0, 1'b1);
      tests++; if (priority_rotate !== 3'd5 || isr !== 8'h00) begin failures++; $display("FAIL t4_rotate got rot=%0d isr=%h exp rot=5 isr=00", priority_rotate, isr); end
      do_inta(8'h40);
      do_inta(8'h01);
      tests++; if (isr !== 8'h41) begin failures++; $display("FAIL t4_setup got %h exp 41", isr); end
      tests++; if (highest_level_in_service !== 8'h40) begin failures++; $display("FAIL t4_hlis got %h exp 40", highest_level_in_service); end
      eoi(1'b0, 3'd0, 1'b0);
      tests++; if (isr !== 8'h01 || highest_level_in_service !== 8'h01) begin failures++; $display("FAIL t4_nonspec got isr=%h hlis=%h exp 01/01", isr, highest_level_in_service); end
   endtask

   task automatic test_spurious;
      vector_base = 5'h0A; interrupt = 8'h00;
      inta_n = 1'b0; tick;
      tests++; if (isr !== 8'h01 || clear_irr !== 8'h00) begin failures++; $display("FAIL t5_untouched got isr=%h clr=%h exp 01/00", isr, clear_irr); end
      inta_n = 1'b1; tick;
      inta_n = 1'b0; tick;
      tests++; if (data_out !== 8'h57 || data_out_en !== 1'b1) begin failures++; $display("FAIL t5_vector got d=%h en=%b exp d=57 en=1", data_out, data_out_en); end
      inta_n = 1'b1; tick;
      tests++; if (isr !== 8'h01) begin failures++; $display("FAIL t5_end got %h exp 01", isr); end
   endtask

   task automatic test_simultaneous;
      interrupt = 8'h04; tick;
      inta_n = 1'b0; eoi_strobe = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd0;
      tick;
      eoi_strobe = 1'b0; eoi_specific = 1'b0;
      tests++; if (isr !== 8'h04) begin failures++; $display("FAIL t7_diff_bits got %h exp 04", isr); end
      finish_inta;
      interrupt = 8'h04; tick;
      inta_n = 1'b0; eoi_strobe = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
      tick;
      eoi_strobe = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
      tests++; if (isr !== 8'h04) begin failures++; $display("FAIL t7_same_bit got %h exp 04", isr); end
      finish_inta;
   endtask

   task automatic test_reset_in_ack2;
      interrupt = 8'h10; tick;
      inta_n = 1'b0; tick;
      inta_n = 1'b1; interrupt = 8'h00; tick;
      inta_n = 1'b0; tick;
      tests++; if (data_out_en !== 1'b1 || isr !== 8'h14) begin failures++; $display("FAIL t6_pre got en=%b isr=%h exp en=1 isr=14", data_out_en, isr); end
      reset = 1'b1; tick;
      tests++; if (int_out !== 1'b0 || isr !== 8'h00 || clear_irr !== 8'h00 || priority_rotate !== 3'd7 || data_out !== 8'h00 || data_out_en !== 1'b0) begin
         failures++;
         $display("FAIL t6_reset got int=%b isr=%h clr=%h rot=%0d d=%h en=%b exp 0/00/00/7/00/0", int_out, isr, clear_irr, priority_rotate, data_out, data_out_en);
      end
      reset = 1'b0; inta_n = 1'b1; interrupt = 8'h02; tick;
      tests++; if (int_out !== 1'b1) begin failures++; $display("FAIL t6_idle_int got %b exp 1", int_out); end
      inta_n = 1'b0; tick;
      tests++; if (isr !== 8'h02 || clear_irr !== 8'h02) begin failures++; $display("FAIL t6_idle_ack got isr=%h clr=%h exp 02/02", isr, clear_irr); end
      finish_inta;
   endtask

   initial begin
      test_reset;
      test_basic_inta;
      test_eoi;
      test_aeoi;
      test_rotate;
      test_spurious;
      test_simultaneous;
      test_reset_in_ack2;
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
